// File: rtl/multiplier.sv
// Pipelined binary32 multiplier: decode/multiply, normalise, round, pack.
// Subnormals flush to zero on input and output; NaN results are canonical.
module multiplier #(
  parameter int LATENCY = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  output logic [31:0] product
);

  localparam logic [31:0] QNAN = 32'h7FC00000;

  logic [LATENCY-1:0] vld;

  logic [7:0]         ea, eb;
  logic               a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic               d_sign;
  logic signed [9:0]  d_exp;
  logic [47:0]        d_mant;
  logic               d_spec;
  logic [31:0]        d_spec_val;

  logic               s1_sign;
  logic signed [9:0]  s1_exp;
  logic [47:0]        s1_mant;
  logic               s1_spec;
  logic [31:0]        s1_spec_val;

  logic signed [9:0]  n_exp;
  logic [22:0]        n_frac;
  logic               n_guard, n_sticky;

  logic               s2_sign;
  logic signed [9:0]  s2_exp;
  logic [22:0]        s2_frac;
  logic               s2_guard, s2_sticky;
  logic               s2_spec;
  logic [31:0]        s2_spec_val;

  logic               round_up, r_carry;
  logic [22:0]        r_frac;
  logic signed [9:0]  r_exp;

  logic               s3_sign;
  logic signed [9:0]  s3_exp;
  logic [22:0]        s3_frac;
  logic               s3_spec;
  logic [31:0]        s3_spec_val;

  logic [31:0]        packed_val;

  assign ea     = a[30:23];
  assign eb     = b[30:23];
  assign a_zero = (ea == 8'h00);
  assign b_zero = (eb == 8'h00);
  assign a_inf  = (ea == 8'hFF) && (a[22:0] == 23'h0);
  assign b_inf  = (eb == 8'hFF) && (b[22:0] == 23'h0);
  assign a_nan  = (ea == 8'hFF) && (a[22:0] != 23'h0);
  assign b_nan  = (eb == 8'hFF) && (b[22:0] != 23'h0);
  assign d_sign = a[31] ^ b[31];
  assign d_exp  = $signed(10'(ea) + 10'(eb) - 10'd127);
  assign d_mant = {1'b1, a[22:0]} * {1'b1, b[22:0]};

  // Special operands bypass the arithmetic and ride the pipe as a ready-made result.
  always_comb begin
    d_spec     = 1'b0;
    d_spec_val = 32'h0;
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
      d_spec     = 1'b1;
      d_spec_val = QNAN;
    end else if (a_inf || b_inf) begin
      d_spec     = 1'b1;
      d_spec_val = {d_sign, 8'hFF, 23'h0};
    end else if (a_zero || b_zero) begin
      d_spec     = 1'b1;
      d_spec_val = {d_sign, 31'h0};
    end
  end

  // Product of two normalised significands lies in [1,4), so bit 46 or 47 leads.
  always_comb begin
    n_exp    = s1_exp;
    n_frac   = s1_mant[45:23];
    n_guard  = s1_mant[22];
    n_sticky = |s1_mant[21:0];
    if (s1_mant[47]) begin
      n_exp    = s1_exp + 10'sd1;
      n_frac   = s1_mant[46:24];
      n_guard  = s1_mant[23];
      n_sticky = |s1_mant[22:0];
    end
  end

  // A carry out of the fraction means 1.111..1 rounded to 10.000..0; fraction is already zero.
  assign round_up          = s2_guard & (s2_sticky | s2_frac[0]);
  assign {r_carry, r_frac} = {1'b0, s2_frac} + 24'(round_up);
  assign r_exp             = s2_exp + $signed(10'(r_carry));

  always_comb begin
    packed_val = {s3_sign, s3_exp[7:0], s3_frac};
    if (s3_spec) begin
      packed_val = s3_spec_val;
    end else if (s3_exp >= 10'sd255) begin
      packed_val = {s3_sign, 8'hFF, 23'h0};
    end else if (s3_exp <= 10'sd0) begin
      packed_val = {s3_sign, 31'h0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld         <= '0;
      out_valid   <= 1'b0;
      product     <= 32'h0;
      s1_sign     <= 1'b0;
      s1_exp      <= '0;
      s1_mant     <= '0;
      s1_spec     <= 1'b0;
      s1_spec_val <= '0;
      s2_sign     <= 1'b0;
      s2_exp      <= '0;
      s2_frac     <= '0;
      s2_guard    <= 1'b0;
      s2_sticky   <= 1'b0;
      s2_spec     <= 1'b0;
      s2_spec_val <= '0;
      s3_sign     <= 1'b0;
      s3_exp      <= '0;
      s3_frac     <= '0;
      s3_spec     <= 1'b0;
      s3_spec_val <= '0;
    end else begin
      vld         <= {vld[LATENCY-2:0], in_valid};
      out_valid   <= vld[LATENCY-1];
      if (vld[LATENCY-1]) begin
        product <= packed_val;
      end
      s1_sign     <= d_sign;
      s1_exp      <= d_exp;
      s1_mant     <= d_mant;
      s1_spec     <= d_spec;
      s1_spec_val <= d_spec_val;
      s2_sign     <= s1_sign;
      s2_exp      <= n_exp;
      s2_frac     <= n_frac;
      s2_guard    <= n_guard;
      s2_sticky   <= n_sticky;
      s2_spec     <= s1_spec;
      s2_spec_val <= s1_spec_val;
      s3_sign     <= s2_sign;
      s3_exp      <= r_exp;
      s3_frac     <= r_frac;
      s3_spec     <= s2_spec;
      s3_spec_val <= s2_spec_val;
    end
  end

endmodule

// File: tb/tb_multiplier.sv
// Scoreboard bench for the binary32 multiplier: directed vectors plus a
// random stream checked against a double-precision reference.
module tb_multiplier;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] a, b;
  logic        out_valid;
  logic [31:0] product;

  int          tests_run    = 0;
  int          tests_failed = 0;
  int          cyc          = 0;
  logic [31:0] exp_q[$];
  int          cyc_q[$];
  string       name_q[$];
  logic [31:0] last_prod    = 32'h0;

  always #5 clk = ~clk;

  multiplier #(.LATENCY(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .product   (product)
  );

  always @(posedge clk) cyc++;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    tests_run++;
    if (act !== req) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Output should appear at the 4th posedge after the negedge that drives it.
  task automatic applyStimulus(input logic [31:0] va, input logic [31:0] vb,
                               input logic [31:0] expv, input string name);
    @(negedge clk);
    in_valid = 1'b1;
    a        = va;
    b        = vb;
    exp_q.push_back(expv);
    cyc_q.push_back(cyc + 4);
    name_q.push_back(name);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      a        = $urandom;
      b        = $urandom;
    end
  endtask

  // Exact double product of the two significands, then RNE down to 24 bits.
  function automatic logic [31:0] model(input logic [31:0] x, input logic [31:0] y);
    logic        s;
    logic        xz, yz, xi, yi, xn, yn;
    real         rx, ry, rp;
    logic [63:0] bits;
    int          e;
    logic [24:0] m;
    s  = x[31] ^ y[31];
    xz = (x[30:23] == 8'h00);
    yz = (y[30:23] == 8'h00);
    xi = (x[30:23] == 8'hFF) && (x[22:0] == 23'h0);
    yi = (y[30:23] == 8'hFF) && (y[22:0] == 23'h0);
    xn = (x[30:23] == 8'hFF) && (x[22:0] != 23'h0);
    yn = (y[30:23] == 8'hFF) && (y[22:0] != 23'h0);
    if (xn || yn || (xi && yz) || (yi && xz)) return 32'h7FC00000;
    if (xi || yi) return {s, 8'hFF, 23'h0};
    if (xz || yz) return {s, 31'h0};
    rx   = $bitstoreal({1'b0, 11'(x[30:23]) + 11'd896, x[22:0], 29'd0});
    ry   = $bitstoreal({1'b0, 11'(y[30:23]) + 11'd896, y[22:0], 29'd0});
    rp   = rx * ry;
    bits = $realtobits(rp);
    e    = int'(bits[62:52]) - 1023 + 127;
    m    = {2'b01, bits[51:29]};
    if (bits[28] && ((|bits[27:0]) || m[0])) m = m + 25'd1;
    if (m[24]) e++;
    if (e >= 255) return {s, 8'hFF, 23'h0};
    if (e <= 0) return {s, 31'h0};
    return {s, 8'(e), m[22:0]};
  endfunction

  function automatic logic [31:0] rand_op();
    logic [31:0] v;
    v = $urandom;
    case ($urandom_range(0, 9))
      0:       v[30:23] = 8'h00;
      1:       v[30:23] = 8'hFF;
      2:       v[30:23] = 8'($urandom_range(1, 254));
      3:       v[22:0]  = 23'h7FFFFF;
      default: v[30:23] = 8'($urandom_range(100, 154));
    endcase
    return v;
  endfunction

  // Monitor: pops the scoreboard on every strobe, checks hold value otherwise.
  always @(posedge clk) begin
    logic [31:0] e;
    int          c;
    string       n;
    #1;
    if (rst_n) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("[TB] FAIL unexpected_out_valid: got 1, expected 0 at cycle %0d", cyc);
        end else begin
          e = exp_q.pop_front();
          c = cyc_q.pop_front();
          n = name_q.pop_front();
          checkOutput(n, product, e);
          checkOutput({n, "_latency"}, 32'(cyc), 32'(c));
          last_prod = e;
        end
      end else begin
        checkOutput("hold", product, last_prod);
      end
    end
  end

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    a        = 32'h0;
    b        = 32'h0;
    #2;
    checkOutput("reset_product", product, 32'h0);
    checkOutput("reset_out_valid", {31'd0, out_valid}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(32'h42FA4000, 32'h41410000, 32'h44BCAA40, "exact_125x12");
    applyStimulus(32'h41000000, 32'h41000000, 32'h42800000, "exact_8x8");
    applyStimulus(32'h3E200000, 32'hBF000000, 32'hBDA00000, "exact_neg");
    applyStimulus(32'h3F800000, 32'hC02DF854, 32'hC02DF854, "exact_one");
    idle(1);
    applyStimulus(32'h41000000, 32'h00000000, 32'h00000000, "zero");
    applyStimulus(32'hBF800000, 32'h00000000, 32'h80000000, "neg_zero");
    applyStimulus(32'h7F800000, 32'h00000000, 32'h7FC00000, "inf_x_zero");
    applyStimulus(32'h7F800000, 32'hBF800000, 32'hFF800000, "inf_x_neg");
    applyStimulus(32'h7F800000, 32'hFF800000, 32'hFF800000, "inf_x_inf");
    applyStimulus(32'h7FC00001, 32'h3F800000, 32'h7FC00000, "nan");
    idle(2);
    applyStimulus(32'h00000001, 32'h3F800000, 32'h00000000, "subnormal");
    applyStimulus(32'h3F800001, 32'h3F800001, 32'h3F800002, "round_nearest");
    applyStimulus(32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE, "norm_shift");
    applyStimulus(32'h3FC00000, 32'h3F800001, 32'h3FC00002, "tie_up_even");
    applyStimulus(32'h3FC00000, 32'h3F800003, 32'h3FC00004, "tie_down_even");
    applyStimulus(32'h3FFFFFFF, 32'h3F800001, 32'h40000000, "round_carry");
    applyStimulus(32'h7F000000, 32'h40000000, 32'h7F800000, "overflow");
    applyStimulus(32'h00800000, 32'h3F000000, 32'h00000000, "underflow");
    applyStimulus(32'hC20E999A, 32'hC2B90000, 32'h454E1A01, "neg_x_neg");
    applyStimulus(32'h40000000, 32'h40400000, 32'h40C00000, "sign_pp");
    applyStimulus(32'hC0000000, 32'h40400000, 32'hC0C00000, "sign_np");
    applyStimulus(32'h40000000, 32'hC0400000, 32'hC0C00000, "sign_pn");
    applyStimulus(32'hC0000000, 32'hC0400000, 32'h40C00000, "sign_nn");
    idle(6);

    applyStimulus(32'h41000000, 32'h41000000, 32'h42800000, "inflight0");
    applyStimulus(32'h40000000, 32'h40400000, 32'h40C00000, "inflight1");
    applyStimulus(32'h3F800000, 32'hC02DF854, 32'hC02DF854, "inflight2");
    @(negedge clk);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    cyc_q.delete();
    name_q.delete();
    last_prod = 32'h0;
    #1;
    checkOutput("midrst_product", product, 32'h0);
    checkOutput("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(6);

    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        idle(1);
      end else begin
        logic [31:0] ra, rb;
        ra = rand_op();
        rb = rand_op();
        applyStimulus(ra, rb, model(ra, rb), "random");
      end
    end

    idle(1);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle(1);
    checkOutput("drain_pending", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
